// File: rtl/instr_decoder_pkg.sv
// Types shared between the instruction decoder and the multi-cycle sequencer.
package instr_decoder_pkg;
    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;
endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with PC, retire counter and traps.
// IDLE|stopped  FETCH|imem handshake  DECODE|classify  EXEC|alu+branch  MEM|dmem handshake  WB|retire  TRAP|fault held
module multicycle_ctrl
    import instr_decoder_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_o,
    input  logic             dec_reg_write_i,
    input  logic             dec_branch_i,
    input  alu_op_e          dec_alu_ctrl_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic             alu_en_o,
    output alu_op_e          alu_ctrl_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_gnt_i,
    output logic             rf_we_o,
    output logic [31:0]      pc_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] retired_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Down-counter loaded on entry to a handshake; expiry is the wait cycle that sees zero.
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [31:0]   pc;
    logic [TW-1:0] wait_cnt;
    logic          reg_write_q;
    logic          branch_q;
    logic          mem_q;
    logic          store_q;
    logic          take_q;
    logic [31:0]   target_q;
    logic          op_legal;
    logic          op_mem;
    logic          op_store;

    always_comb begin
        op_legal = 1'b1;
        op_mem   = 1'b0;
        op_store = 1'b0;
        case (instr_o[6:0])
            7'b0110011, 7'b0010011, 7'b1100011: op_legal = 1'b1;
            7'b0000011: op_mem = 1'b1;
            7'b0100011: begin
                op_mem   = 1'b1;
                op_store = 1'b1;
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_o     <= 32'h0;
            alu_ctrl_o  <= ALU_NOP;
            retired_o   <= '0;
            illegal_o   <= 1'b0;
            bus_err_o   <= 1'b0;
            wait_cnt    <= '0;
            reg_write_q <= 1'b0;
            branch_q    <= 1'b0;
            mem_q       <= 1'b0;
            store_q     <= 1'b0;
            take_q      <= 1'b0;
            target_q    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        pc       <= RESET_PC;
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_gnt_i) begin
                        instr_o <= imem_rdata_i;
                        state   <= S_DECODE;
                    end else if (TIMEOUT != 0 && wait_cnt == '0) begin
                        bus_err_o <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end
                end
                S_DECODE: begin
                    alu_ctrl_o  <= dec_alu_ctrl_i;
                    reg_write_q <= dec_reg_write_i;
                    branch_q    <= dec_branch_i;
                    mem_q       <= op_mem;
                    store_q     <= op_store;
                    if (!op_legal) begin
                        illegal_o <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    take_q   <= branch_q & branch_taken_i;
                    target_q <= branch_target_i;
                    if (mem_q) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_gnt_i) begin
                        state <= S_WB;
                    end else if (TIMEOUT != 0 && wait_cnt == '0) begin
                        bus_err_o <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt - TW'(1);
                    end
                end
                S_WB: begin
                    retired_o <= retired_o + CNT_W'(1);
                    pc        <= take_q ? target_q : pc + 32'd4;
                    if (stop_i) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    if (start_i) begin
                        illegal_o <= 1'b0;
                        bus_err_o <= 1'b0;
                        pc        <= RESET_PC;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o  = (state == S_FETCH);
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign alu_en_o    = (state == S_EXEC);
    assign dmem_req_o  = (state == S_MEM);
    assign dmem_we_o   = (state == S_MEM) && store_q;
    assign rf_we_o     = (state == S_WB) && reg_write_q;
    assign busy_o      = (state != S_IDLE) && (state != S_TRAP);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: per-instruction cycle schedules are derived from the sequencing rules and compared every cycle.
module tb_multicycle_ctrl;
    import instr_decoder_pkg::*;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0, stop_i = 1'b0;
    logic        imem_req_o, imem_gnt_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = 32'h0;
    logic [31:0] instr_o;
    logic        dec_reg_write, dec_branch;
    alu_op_e     dec_alu_ctrl;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        alu_en_o, dmem_req_o, dmem_we_o, dmem_gnt_i = 1'b0, rf_we_o;
    alu_op_e     alu_ctrl_o;
    logic [31:0] pc_o, retired_o;
    logic        busy_o, illegal_o, bus_err_o;

    multicycle_ctrl #(.RESET_PC(32'h0), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
        .dec_reg_write_i(dec_reg_write), .dec_branch_i(dec_branch), .dec_alu_ctrl_i(dec_alu_ctrl),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .alu_en_o(alu_en_o), .alu_ctrl_o(alu_ctrl_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i), .rf_we_o(rf_we_o), .pc_o(pc_o),
        .busy_o(busy_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction classes: 0 illegal, 1 alu, 2 load, 3 store, 4 branch.
    function automatic int cls(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic dec_rw(input logic [31:0] w);
        return (cls(w) == 1) || (cls(w) == 2);
    endfunction

    function automatic alu_op_e dec_alu(input logic [31:0] w);
        case (cls(w))
            1: begin
                if (w[14:12] != 3'b000) return ALU_OR;
                if (w[5] && w[30]) return ALU_SUB;
                return ALU_ADD;
            end
            2, 3: return ALU_ADD;
            4: return ALU_SUB;
            default: return ALU_NOP;
        endcase
    endfunction

    always_comb begin
        dec_reg_write = dec_rw(instr_o);
        dec_branch    = (cls(instr_o) == 4);
        dec_alu_ctrl  = dec_alu(instr_o);
    end

    typedef struct {
        string       tag;
        logic        imem_req;
        logic [31:0] imem_addr;
        logic        dmem_req, dmem_we, alu_en, rf_we, busy, illegal, bus_err;
        logic [31:0] retired, pc;
        logic        chk_instr;
        logic [31:0] instr;
        logic        chk_alu;
        alu_op_e     alu;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_retired = 32'h0;
    logic        m_illegal = 1'b0, m_bus_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t base(input string tag);
        exp_t e;
        e.tag = tag; e.imem_req = 1'b0; e.imem_addr = m_pc;
        e.dmem_req = 1'b0; e.dmem_we = 1'b0; e.alu_en = 1'b0; e.rf_we = 1'b0;
        e.busy = 1'b1; e.illegal = m_illegal; e.bus_err = m_bus_err;
        e.retired = m_retired; e.pc = m_pc;
        e.chk_instr = 1'b0; e.instr = 32'h0; e.chk_alu = 1'b0; e.alu = ALU_NOP;
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk({cur.tag, ":imem_req"}, 32'(imem_req_o), 32'(cur.imem_req));
            if (cur.imem_req) chk({cur.tag, ":imem_addr"}, imem_addr_o, cur.imem_addr);
            chk({cur.tag, ":dmem_req"}, 32'(dmem_req_o), 32'(cur.dmem_req));
            if (cur.dmem_req) chk({cur.tag, ":dmem_we"}, 32'(dmem_we_o), 32'(cur.dmem_we));
            chk({cur.tag, ":alu_en"}, 32'(alu_en_o), 32'(cur.alu_en));
            chk({cur.tag, ":rf_we"}, 32'(rf_we_o), 32'(cur.rf_we));
            chk({cur.tag, ":busy"}, 32'(busy_o), 32'(cur.busy));
            chk({cur.tag, ":illegal"}, 32'(illegal_o), 32'(cur.illegal));
            chk({cur.tag, ":bus_err"}, 32'(bus_err_o), 32'(cur.bus_err));
            chk({cur.tag, ":retired"}, retired_o, cur.retired);
            chk({cur.tag, ":pc"}, pc_o, cur.pc);
            if (cur.chk_instr) chk({cur.tag, ":instr"}, instr_o, cur.instr);
            if (cur.chk_alu) chk({cur.tag, ":alu_ctrl"}, 32'(alu_ctrl_o), 32'(cur.alu));
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        imem_gnt_i = 1'b0; dmem_gnt_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            stop_i = 1'b1;
            e = base("idle"); e.busy = 1'b0;
            exp_q.push_back(e);
            next_cycle();
        end
    endtask

    task automatic do_start();
        exp_t e;
        start_i = 1'b1;
        e = base("start"); e.busy = 1'b0;
        exp_q.push_back(e);
        next_cycle();
        m_illegal = 1'b0; m_bus_err = 1'b0; m_pc = 32'h0;
    endtask

    task automatic run_timeout();
        exp_t e;
        for (int i = 0; i < TO; i++) begin
            e = base("fetch_wait"); e.imem_req = 1'b1;
            exp_q.push_back(e);
            next_cycle();
        end
        m_bus_err = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] word, input int idly, input int ddly,
                             input bit taken, input logic [31:0] tgt, input bit stop, input bit rst_mem);
        exp_t e;
        int   c;
        c = cls(word);
        for (int i = 0; i <= idly; i++) begin
            imem_rdata_i = word; imem_gnt_i = (i == idly); start_i = (idly > 0);
            e = base("fetch"); e.imem_req = 1'b1;
            exp_q.push_back(e);
            next_cycle();
        end
        e = base("decode"); e.chk_instr = 1'b1; e.instr = word;
        exp_q.push_back(e);
        next_cycle();
        if (c == 0) begin
            m_illegal = 1'b1;
            e = base("trap"); e.busy = 1'b0;
            exp_q.push_back(e);
            next_cycle();
            return;
        end
        branch_taken_i = taken; branch_target_i = tgt;
        e = base("exec"); e.alu_en = 1'b1; e.chk_alu = 1'b1; e.alu = dec_alu(word);
        exp_q.push_back(e);
        next_cycle();
        if (c == 2 || c == 3) begin
            for (int j = 0; j <= ddly; j++) begin
                dmem_gnt_i = (j == ddly);
                if (rst_mem && j == 1) begin
                    #1 rst_i = 1'b1;
                    #1 chk("async_rst_dmem_req", 32'(dmem_req_o), 32'h0);
                    m_pc = 32'h0; m_retired = 32'h0; m_illegal = 1'b0; m_bus_err = 1'b0;
                    e = base("in_reset"); e.busy = 1'b0; e.chk_instr = 1'b1; e.instr = 32'h0;
                    e.chk_alu = 1'b1; e.alu = ALU_NOP;
                    exp_q.push_back(e);
                    next_cycle();
                    rst_i = 1'b0;
                    return;
                end
                e = base("mem"); e.dmem_req = 1'b1; e.dmem_we = (c == 3);
                exp_q.push_back(e);
                next_cycle();
            end
        end
        stop_i = stop;
        e = base("wb"); e.rf_we = dec_rw(word);
        exp_q.push_back(e);
        next_cycle();
        m_retired = m_retired + 32'd1;
        m_pc = (c == 4 && taken) ? tgt : m_pc + 32'd4;
    endtask

    localparam logic [31:0] I_ADD   = 32'h0000_0033;
    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LOAD  = 32'h0000_2103;
    localparam logic [31:0] I_STORE = 32'h0020_2223;
    localparam logic [31:0] I_BEQ   = 32'h0000_0063;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    initial begin
        #2 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_imem_req", 32'(imem_req_o), 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_retired", retired_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl_o), 32'(ALU_NOP));
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;

        idle(2);
        do_start();
        run_instr(I_ADD, 0, 0, 0, 32'h0, 0, 0);
        chk("after_add_addr", imem_addr_o, 32'h4);
        chk("after_add_alu", 32'(alu_ctrl_o), 32'(ALU_ADD));
        run_instr(I_ADDI, 0, 0, 0, 32'h0, 0, 0);
        chk("after_addi_retired", retired_o, 32'd2);
        chk("after_addi_addr", imem_addr_o, 32'h8);

        run_instr(I_LOAD, 0, 3, 0, 32'h0, 0, 0);
        run_instr(I_STORE, 0, 3, 0, 32'h0, 0, 0);
        chk("after_ldst_addr", imem_addr_o, 32'h10);

        run_instr(I_BEQ, 0, 0, 1, 32'h40, 0, 0);
        chk("beq_taken_addr", imem_addr_o, 32'h40);
        run_instr(I_BEQ, 1, 0, 1, 32'h10, 0, 0);
        run_instr(I_BEQ, 0, 0, 0, 32'h80, 0, 0);
        chk("beq_not_taken_addr", imem_addr_o, 32'h14);

        run_instr(I_BAD, 0, 0, 0, 32'h0, 0, 0);
        chk("illegal_flag", 32'(illegal_o), 32'h1);
        chk("illegal_pc", pc_o, 32'h14);
        chk("illegal_retired", retired_o, 32'd7);
        idle(2);
        do_start();
        run_instr(I_ADD, 1, 0, 0, 32'h0, 1, 0);
        chk("stop_busy", 32'(busy_o), 32'h0);
        chk("stop_retired", retired_o, 32'd8);
        idle(1);

        do_start();
        run_timeout();
        chk("timeout_bus_err", 32'(bus_err_o), 32'h1);
        chk("timeout_req_drop", 32'(imem_req_o), 32'h0);
        idle(1);
        do_start();
        run_instr(I_ADD, TO - 1, 0, 0, 32'h0, 0, 0);
        chk("late_gnt_no_err", 32'(bus_err_o), 32'h0);

        run_instr(I_LOAD, 0, 5, 0, 32'h0, 0, 1);
        idle(1);
        do_start();
        run_instr(I_ADD, 0, 0, 0, 32'h0, 1, 0);
        chk("post_reset_retired", retired_o, 32'd1);
        idle(1);

        @(negedge clk_i);
        #1;
        chk("schedule_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
